// File: rtl/led_phase_scheduler.sv
// Time-multiplexes the RED, IR and optional ambient (DARK) measurement phases of a
// pulse-oximetry front end and averages the ADC samples taken in each phase.
module led_phase_scheduler #(
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLE_CYCLES = 4,
    parameter int DARK_EN       = 1
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       cfg_load,
    input  logic [6:0] RED_DC_Comp_in,
    input  logic [6:0] IR_DC_Comp_in,
    input  logic [3:0] RED_PGA_in,
    input  logic [3:0] IR_PGA_in,
    input  logic [7:0] ADC,
    output logic       LED_RED,
    output logic       LED_IR,
    output logic [6:0] DC_Comp,
    output logic [3:0] PGA_Gain,
    output logic [7:0] RED_ADC_Value,
    output logic [7:0] IR_ADC_Value,
    output logic [7:0] DARK_ADC_Value,
    output logic       sample_valid,
    output logic       busy,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        RED_SETTLE  = 3'd1,
        RED_SAMPLE  = 3'd2,
        IR_SETTLE   = 3'd3,
        IR_SAMPLE   = 3'd4,
        DARK_SETTLE = 3'd5,
        DARK_SAMPLE = 3'd6
    } state_e;

    localparam int         SHIFT       = $clog2(SAMPLE_CYCLES);
    localparam int         ACC_W       = 8 + SHIFT;
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   sum;
    logic [7:0]         avg;
    logic [6:0]         red_dc_q, red_dc_d, ir_dc_q, ir_dc_d;
    logic [3:0]         red_pga_q, red_pga_d, ir_pga_q, ir_pga_d;
    logic               led_red_q, led_red_d, led_ir_q, led_ir_d;
    logic [6:0]         dc_q, dc_d;
    logic [3:0]         pga_q, pga_d;
    logic [7:0]         red_val_q, red_val_d, ir_val_q, ir_val_d, dark_val_q, dark_val_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               is_sample, phase_end, last_sample;

    // Sum includes the ADC value present in the final sample cycle.
    assign sum = acc_q + ACC_W'(ADC);
    assign avg = 8'(sum >> SHIFT);

    always_comb begin
        is_sample   = (state_q == RED_SAMPLE) || (state_q == IR_SAMPLE) || (state_q == DARK_SAMPLE);
        phase_end   = is_sample && (cnt_q == SAMPLE_LAST) && enable;
        last_sample = (DARK_EN != 0) ? (state_q == DARK_SAMPLE) : (state_q == IR_SAMPLE);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (enable) state_d = RED_SETTLE;
            RED_SETTLE:  if (cnt_q == SETTLE_LAST) state_d = RED_SAMPLE;
            RED_SAMPLE:  if (cnt_q == SAMPLE_LAST) state_d = IR_SETTLE;
            IR_SETTLE:   if (cnt_q == SETTLE_LAST) state_d = IR_SAMPLE;
            IR_SAMPLE: begin
                if (cnt_q == SAMPLE_LAST) begin
                    if (DARK_EN != 0) state_d = DARK_SETTLE;
                    else              state_d = RED_SETTLE;
                end
            end
            DARK_SETTLE: if (cnt_q == SETTLE_LAST) state_d = DARK_SAMPLE;
            DARK_SAMPLE: if (cnt_q == SAMPLE_LAST) state_d = RED_SETTLE;
            default:     state_d = IDLE;
        endcase
        // Dropping enable aborts from anywhere; the partial frame is discarded.
        if (!enable) state_d = IDLE;
    end

    always_comb begin
        cnt_d = (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
        if (state_d != state_q) acc_d = '0;
        else if (is_sample)     acc_d = sum;
        else                    acc_d = acc_q;

        red_dc_d  = red_dc_q;
        ir_dc_d   = ir_dc_q;
        red_pga_d = red_pga_q;
        ir_pga_d  = ir_pga_q;
        if ((state_q == IDLE) && cfg_load) begin
            red_dc_d  = RED_DC_Comp_in;
            ir_dc_d   = IR_DC_Comp_in;
            red_pga_d = RED_PGA_in;
            ir_pga_d  = IR_PGA_in;
        end

        red_val_d  = red_val_q;
        ir_val_d   = ir_val_q;
        dark_val_d = dark_val_q;
        if (phase_end) begin
            case (state_q)
                RED_SAMPLE:  red_val_d  = avg;
                IR_SAMPLE:   ir_val_d   = avg;
                DARK_SAMPLE: dark_val_d = avg;
                default:     ;
            endcase
        end
        valid_d = phase_end && last_sample;
        busy_d  = (state_d != IDLE);
    end

    // Front-end outputs are decoded from the next state so they register in step with it.
    always_comb begin
        led_red_d = 1'b0;
        led_ir_d  = 1'b0;
        dc_d      = red_dc_d;
        pga_d     = red_pga_d;
        case (state_d)
            IDLE: begin
                dc_d  = '0;
                pga_d = '0;
            end
            RED_SETTLE, RED_SAMPLE: led_red_d = 1'b1;
            IR_SETTLE, IR_SAMPLE: begin
                led_ir_d = 1'b1;
                dc_d     = ir_dc_d;
                pga_d    = ir_pga_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            red_dc_q   <= '0;
            ir_dc_q    <= '0;
            red_pga_q  <= '0;
            ir_pga_q   <= '0;
            led_red_q  <= 1'b0;
            led_ir_q   <= 1'b0;
            dc_q       <= '0;
            pga_q      <= '0;
            red_val_q  <= '0;
            ir_val_q   <= '0;
            dark_val_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            red_dc_q   <= red_dc_d;
            ir_dc_q    <= ir_dc_d;
            red_pga_q  <= red_pga_d;
            ir_pga_q   <= ir_pga_d;
            led_red_q  <= led_red_d;
            led_ir_q   <= led_ir_d;
            dc_q       <= dc_d;
            pga_q      <= pga_d;
            red_val_q  <= red_val_d;
            ir_val_q   <= ir_val_d;
            dark_val_q <= dark_val_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign LED_RED        = led_red_q;
    assign LED_IR         = led_ir_q;
    assign DC_Comp        = dc_q;
    assign PGA_Gain       = pga_q;
    assign RED_ADC_Value  = red_val_q;
    assign IR_ADC_Value   = ir_val_q;
    assign DARK_ADC_Value = dark_val_q;
    assign sample_valid   = valid_q;
    assign busy           = busy_q;
    assign state_o        = state_q;

endmodule

// File: doc/led_phase_scheduler.md
LED_PHASE_SCHEDULER -- requirements
Module: led_phase_scheduler

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: cycles per phase with LED on before sampling (legal 1..255).
REQ-002 SHALL have parameter SAMPLE_CYCLES, default 4: ADC samples averaged per phase (power of two, legal 1..16).
REQ-003 SHALL have parameter DARK_EN, default 1: 1 adds an ambient phase with both LEDs off.
REQ-004 SHALL use one clock and an asynchronous active-low reset, ports as follows:
REQ-005 CLK  in  1  sole clock; all state changes on posedge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 enable  in  1  level; 1 runs frames continuously, 0 aborts to IDLE.
REQ-008 cfg_load  in  1  one-cycle strobe; captures the four cfg inputs.
REQ-009 RED_DC_Comp_in / IR_DC_Comp_in  in  7 each  calibrated DC compensation codes.
REQ-010 RED_PGA_in / IR_PGA_in  in  4 each  calibrated PGA gains.
REQ-011 ADC  in  8  converter output, valid every cycle.
REQ-012 LED_RED, LED_IR  out  1 each  LED enables.
REQ-013 DC_Comp  out  7; PGA_Gain  out  4: analog front-end settings for the current phase.
REQ-014 RED_ADC_Value, IR_ADC_Value, DARK_ADC_Value  out  8 each  per-phase averaged results.
REQ-015 sample_valid  out  1  one-cycle pulse, frame results updated.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, RED_SETTLE, RED_SAMPLE, IR_SETTLE, IR_SAMPLE, DARK_SETTLE, DARK_SAMPLE.
REQ-018 IDLE -> RED_SETTLE on the first edge with enable=1; X_SETTLE -> X_SAMPLE after SETTLE_CYCLES cycles; X_SAMPLE -> next phase's SETTLE after SAMPLE_CYCLES cycles; order RED, IR, DARK (DARK skipped when DARK_EN=0).
REQ-019 After the last sample state, the FSM SHALL go to RED_SETTLE if enable=1, else IDLE; no idle gap between frames.
REQ-020 Frame length SHALL be (2+DARK_EN)*(SETTLE_CYCLES+SAMPLE_CYCLES) cycles (24 with defaults).
REQ-021 enable=0 in any non-IDLE state SHALL force IDLE at the next edge: no result update, no sample_valid.
REQ-022 cfg_load SHALL be honoured only in IDLE; while busy=1 it SHALL be ignored, so settings never change mid-frame.
REQ-023 Outputs SHALL be registered and state-decoded: RED states give LED_RED=1, LED_IR=0, RED cfg; IR states give LED_RED=0, LED_IR=1, IR cfg; DARK states give both LEDs 0, RED cfg; IDLE gives both LEDs 0, DC_Comp=0, PGA_Gain=0.
REQ-024 LED_RED and LED_IR SHALL never be high in the same cycle.
REQ-025 The accumulator (8+log2(SAMPLE_CYCLES) bits, no overflow possible) SHALL clear on entering each SETTLE state and add ADC every SAMPLE-state cycle.
REQ-026 On the edge ending a SAMPLE state, the phase result SHALL be set to accumulator (including the final sample) >> log2(SAMPLE_CYCLES), truncated.
REQ-027 sample_valid SHALL be 1 for exactly the cycle after the last sample of a completed frame; all three result registers are stable then.
REQ-028 Result registers SHALL hold their value across aborts and IDLE periods.

Reset
REQ-029 rst_n=0 SHALL immediately give state IDLE, LEDs 0, DC_Comp 0, PGA_Gain 0, all cfg registers 0, all results 0, accumulator 0, counters 0, sample_valid 0, busy 0.
REQ-030 Reset mid-frame SHALL discard the partial frame; operation restarts only on an edge after rst_n=1 with enable=1.

Verification
REQ-031 Defaults: cfg_load RED 50/3, IR 70/5; enable=1; ADC=100 in RED, 200 in IR, 20 in DARK -> values 100/200/20; sample_valid at cycle 24 after first RED_SETTLE; DC_Comp/PGA 50/3 then 70/5 then 50/3.
REQ-032 RED_SAMPLE ADC sequence 1,2,2,2 -> RED_ADC_Value=1; sequence 255,255,255,255 -> 255.
REQ-033 enable dropped in 2nd IR_SAMPLE cycle -> IDLE next edge, LEDs 0, no sample_valid, previous results unchanged.
REQ-034 cfg_load with IR 10/1 during IR_SETTLE -> frame still uses previous IR cfg; after return to IDLE, a new load takes effect.
REQ-035 DARK_EN=0 -> 16-cycle frames, DARK state never entered, DARK_ADC_Value stays 0; continuous enable gives sample_valid every 16 cycles.
REQ-036 rst_n pulsed low during RED_SAMPLE -> all outputs at reset values asynchronously; after release with enable=1, RED_SETTLE entered next edge.
